// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared state encoding and framing constants for the image loader.
package im_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte stream in, instruction-memory write port out.
interface im_loader_if #(parameter int ADDR_W = 10);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] im_ADDR;
  logic [31:0] im_DATA;
  logic im_W;
  modport master (input in_data, in_valid, output in_ready, im_ADDR, im_DATA, im_W);
  modport slave (output in_data, in_valid, input in_ready, im_ADDR, im_DATA, im_W);
endinterface

// File: rtl/im_loader_byte_packer.sv
// byte_packer: little-endian assembly of stream bytes into 32-bit words.
module byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [CW-1:0] r_cnt;
  logic [23:0]   r_low;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_low <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_low <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      r_low <= {i_byte, r_low[23:8]};
    end
  // the 4th byte completes the word combinationally so the loader can register it
  assign o_word       = {i_byte, r_low};
  assign o_word_valid = i_en & (r_cnt == CW'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/im_loader.sv
// im_loader: loads a framed, XOR-checked image into instruction memory and gates core reset.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  im_loader_if.master       bus,
  output logic              cpu_RESET,
  output logic              done,
  output logic              err
);
  state_t r_state, w_next;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_w;
  logic [15:0]       w_len;
  logic [31:0]       w_word;
  logic              w_xfer, w_begin, w_pack_en, w_word_valid, w_last;

  assign bus.in_ready = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign w_xfer       = bus.in_valid & bus.in_ready;
  assign w_begin      = start & (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_pack_en    = w_xfer & (r_state == S_DATA);
  assign w_len        = {bus.in_data, r_len_lo};
  assign w_last       = (r_idx + (ADDR_W+1)'(1)) == r_len;

  byte_packer u_packer (
    .clk(CLK), .rst_n(RESET_N), .i_clr(w_begin), .i_en(w_pack_en),
    .i_byte(bus.in_data), .o_word(w_word), .o_word_valid(w_word_valid)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_next = start ? S_LEN0 : r_state;
      S_LEN0: w_next = w_xfer ? S_LEN1 : S_LEN0;
      S_LEN1: w_next = !w_xfer ? S_LEN1 :
                       (w_len == 16'd0 || {16'd0, w_len} > 32'(DEPTH)) ? S_ERROR : S_DATA;
      S_DATA: w_next = (w_word_valid && w_last) ? S_CSUM : S_DATA;
      S_CSUM: w_next = !w_xfer ? S_CSUM : (bus.in_data == r_csum) ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_len_lo <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_csum   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_w      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_w     <= w_word_valid;
      if (w_begin) begin
        r_idx  <= '0;
        r_csum <= '0;
      end
      if (w_xfer && r_state == S_LEN0) r_len_lo <= bus.in_data;
      if (w_xfer && r_state == S_LEN1) r_len <= w_len[ADDR_W:0];
      if (w_pack_en) r_csum <= r_csum ^ bus.in_data;
      if (w_word_valid) begin
        r_addr <= r_idx[ADDR_W-1:0];
        r_data <= w_word;
        r_idx  <= r_idx + (ADDR_W+1)'(1);
      end
    end

  assign bus.im_ADDR = r_addr;
  assign bus.im_DATA = r_data;
  assign bus.im_W    = r_w;
  assign cpu_RESET   = r_state != S_DONE;
  assign done        = r_state == S_DONE;
  assign err         = r_state == S_ERROR;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for the instruction-memory image loader.
module tb_im_loader;
  import im_loader_pkg::*;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic CLK = 0, RESET_N = 0, start = 0;
  logic cpu_RESET, done, err;
  int checks = 0, failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic [31:0] img[$];

  im_loader_if #(.ADDR_W(AW)) bus();
  im_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .bus(bus.master),
    .cpu_RESET(cpu_RESET), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (RESET_N && bus.im_W) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected addr=%0h data=%h", bus.im_ADDR, bus.im_DATA);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.im_ADDR, bus.im_DATA} !== exp_e) begin
          failures++;
          $display("FAIL write got=%0h/%h exp=%0h/%h", bus.im_ADDR, bus.im_DATA,
                   exp_e[AW+31:32], exp_e[31:0]);
        end
      end
    end

  task automatic pulse_start();
    @(negedge CLK);
    bus.in_valid = 0;
    start = 1;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.in_valid = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge CLK);
      bus.in_valid = 0;
    end
    @(negedge CLK);
    bus.in_data = b;
    bus.in_valid = 1;
    while (!bus.in_ready && n < 16) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout byte=%h in_ready=0 required=1", b);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_image(input int maxgap, input int pulse_at);
    logic [7:0] cs, b;
    int nb;
    cs = 0;
    nb = 0;
    send_byte(img.size() % 256, 0);
    send_byte(img.size() / 256, 0);
    for (int i = 0; i < img.size(); i++)
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        b = img[i][8*k +: 8];
        cs ^= b;
        if (k == BYTES_PER_WORD - 1) exp_q.push_back({AW'(i), img[i]});
        if (nb == pulse_at) begin
          @(negedge CLK);
          bus.in_valid = 0;
          start = 1;
          @(negedge CLK);
          start = 0;
        end
        send_byte(b, maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
        nb++;
      end
    send_byte(cs, 0);
  endtask

  task automatic nominal_frame(input logic [7:0] csum);
    logic [7:0] fr [10];
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'hE0};
    for (int i = 0; i < 10; i++) begin
      if (i == 5) exp_q.push_back({AW'(0), 32'h0000_0013});
      if (i == 9) exp_q.push_back({AW'(1), 32'hE000_0137});
      send_byte(fr[i], 0);
      if (i == 5) begin
        checks++;
        if ({bus.im_W, bus.im_ADDR} !== {1'b1, AW'(0)}) begin
          failures++;
          $display("FAIL write_latency got=%b/%0h exp=1/0", bus.im_W, bus.im_ADDR);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus.im_W !== 1'b0) begin
          failures++;
          $display("FAIL write_pulse_width im_W=%b exp=0", bus.im_W);
        end
      end
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_early done=%b exp=0", done);
    end
    send_byte(csum, 0);
  endtask

  task automatic test_drained(input string tag);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes pending=%0d exp=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.in_ready, bus.im_ADDR, bus.im_DATA, bus.im_W, cpu_RESET, done, err} !==
        {1'b0, AW'(0), 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values rdy=%b addr=%0h data=%h w=%b cpu=%b done=%b err=%b exp=0/0/0/0/1/0/0",
               bus.in_ready, bus.im_ADDR, bus.im_DATA, bus.im_W, cpu_RESET, done, err);
    end
    RESET_N = 1;
    idle(2);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready in_ready=%b exp=0", bus.in_ready);
    end
  endtask

  task automatic test_nominal();
    pulse_start();
    checks++;
    if ({bus.in_ready, cpu_RESET} !== 2'b11) begin
      failures++;
      $display("FAIL start_ready rdy/cpu=%b%b exp=11", bus.in_ready, cpu_RESET);
    end
    nominal_frame(8'hC5);
    checks++;
    if ({done, cpu_RESET, err} !== 3'b100) begin
      failures++;
      $display("FAIL nominal_done done/cpu/err=%b%b%b exp=100", done, cpu_RESET, err);
    end
    test_drained("nominal");
  endtask

  task automatic test_bad_csum();
    pulse_start();
    nominal_frame(8'h00);
    checks++;
    if ({done, cpu_RESET, err} !== 3'b011) begin
      failures++;
      $display("FAIL bad_csum done/cpu/err=%b%b%b exp=011", done, cpu_RESET, err);
    end
    test_drained("bad_csum");
    pulse_start();
    checks++;
    if ({err, cpu_RESET, bus.in_ready} !== 3'b011) begin
      failures++;
      $display("FAIL err_clear err/cpu/rdy=%b%b%b exp=011", err, cpu_RESET, bus.in_ready);
    end
  endtask

  task automatic test_len_zero();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if ({err, bus.in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL len_zero err/rdy=%b%b exp=10", err, bus.in_ready);
    end
    test_drained("len_zero");
  endtask

  task automatic test_len_over();
    pulse_start();
    send_byte(8'(DEPTH + 1), 0);
    send_byte(8'((DEPTH + 1) >> 8), 0);
    checks++;
    if ({err, done} !== 2'b10) begin
      failures++;
      $display("FAIL len_over err/done=%b%b exp=10", err, done);
    end
    test_drained("len_over");
  endtask

  task automatic test_len_depth();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    pulse_start();
    send_image(0, -1);
    checks++;
    if ({done, err, bus.im_ADDR} !== {2'b10, AW'(DEPTH - 1)}) begin
      failures++;
      $display("FAIL len_depth done/err=%b%b addr=%0h exp=10/%0h", done, err, bus.im_ADDR, DEPTH - 1);
    end
    test_drained("len_depth");
  endtask

  task automatic test_stall();
    img = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h8000_0001};
    pulse_start();
    send_image(3, 5);
    checks++;
    if ({done, err, cpu_RESET} !== 3'b100) begin
      failures++;
      $display("FAIL stall_done done/err/cpu=%b%b%b exp=100", done, err, cpu_RESET);
    end
    test_drained("stall");
  endtask

  task automatic test_mid_reset();
    logic [7:0] fr [10];
    fr = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) exp_q.push_back({AW'(0), 32'h4433_2211});
      send_byte(fr[i], 0);
    end
    @(negedge CLK);
    bus.in_valid = 0;
    RESET_N = 0;
    #1;
    checks++;
    if ({bus.in_ready, bus.im_ADDR, bus.im_DATA, bus.im_W, cpu_RESET, done, err} !==
        {1'b0, AW'(0), 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset rdy=%b addr=%0h data=%h w=%b cpu=%b done=%b err=%b exp=0/0/0/0/1/0/0",
               bus.in_ready, bus.im_ADDR, bus.im_DATA, bus.im_W, cpu_RESET, done, err);
    end
    test_drained("mid_reset");
    RESET_N = 1;
    img = '{32'hCAFE_F00D};
    pulse_start();
    send_image(0, -1);
    checks++;
    if ({done, cpu_RESET} !== 2'b10) begin
      failures++;
      $display("FAIL after_reset_load done/cpu=%b%b exp=10", done, cpu_RESET);
    end
    test_drained("after_reset");
  endtask

  task automatic test_reload();
    pulse_start();
    checks++;
    if ({cpu_RESET, done} !== 2'b10) begin
      failures++;
      $display("FAIL reload_start cpu/done=%b%b exp=10", cpu_RESET, done);
    end
    img = '{32'h1111_2222, 32'h3333_4444};
    send_image(1, -1);
    checks++;
    if ({done, cpu_RESET, err} !== 3'b100) begin
      failures++;
      $display("FAIL reload_done done/cpu/err=%b%b%b exp=100", done, cpu_RESET, err);
    end
    test_drained("reload");
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    test_reset();
    test_nominal();
    test_bad_csum();
    test_len_zero();
    test_len_over();
    test_len_depth();
    test_stall();
    test_mid_reset();
    test_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached=1 required=0");
    $fatal(1);
  end
endmodule

// File: doc/im_loader.md
# im_loader

Byte-stream programmer for the instruction memory: the writer side of the instruction-fetch path. It accepts a framed image (length header, little-endian instruction words, XOR checksum) on an 8-bit valid/ready stream, writes each assembled 32-bit word into instruction memory, and holds the processor core in reset until a complete, checksum-verified image has been written.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `DEPTH`, default 1024: maximum accepted word count. Must be ≤ 2^ADDR_W.

Ports:
- `CLK`  in  1  clock. All logic is rising-edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_ADDR`  out  ADDR_W  instruction-memory word address.
- `im_DATA`  out  32  instruction word.
- `im_W`  out  1  one-cycle write strobe to instruction memory.
- `cpu_RESET`  out  1  active-high core reset (PC, register bank, flags, control unit).
- `done`  out  1  image loaded and verified.
- `err`  out  1  load failed (bad length or checksum).

## Operation
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- A byte transfers on a rising edge where `in_valid & in_ready`. `in_ready` is combinational from state: 1 in LEN0, LEN1, DATA, CSUM; 0 otherwise.
- IDLE/DONE/ERROR + `start` -> LEN0. This clears `done` and `err`, asserts `cpu_RESET`, and zeroes the word index and checksum. `start` is ignored in LEN0, LEN1, DATA and CSUM.
- LEN0: byte -> len[7:0]. LEN1: byte -> len[15:8].
  - If len == 0 or len > DEPTH -> ERROR.
  - Otherwise -> DATA.
- DATA: byte k (k = 0..3) of a word goes to bits [8k+7:8k]. Each data byte is XORed into the checksum.
  - On the 4th byte, register `im_DATA` = the assembled word, `im_ADDR` = the word index, and `im_W` = 1 for exactly one cycle. Then increment the index.
  - After word len-1 -> CSUM.
- CSUM: received byte == accumulated XOR -> DONE, else -> ERROR. Header bytes are not included in the checksum.
- DONE: `done` = 1, `cpu_RESET` = 0.
- ERROR: `err` = 1, `cpu_RESET` stays 1.
- Words already written stay in instruction memory after an error or a mid-load reset. No rollback.
- Index arithmetic is ADDR_W+1 bits wide, so len == DEPTH == 2^ADDR_W does not wrap before the compare.

## Timing
- Reset values: state IDLE, `in_ready` 0, `im_ADDR` 0, `im_DATA` 0, `im_W` 0, `cpu_RESET` 1, `done` 0, `err` 0.
- `start` sampled at edge t -> `in_ready` = 1 during cycle t+1.
- Write latency: the 4th byte of word i accepted at edge t -> `im_W` = 1 with that address and data during cycle t+1 only. `im_ADDR`/`im_DATA` hold their values until the next write.
- No backpressure is needed for writes. `in_ready` stays 1 in the cycle of `im_W`, so back-to-back bytes give one write every 4 cycles.
- With `in_valid` held at 1, a load of N words takes 4N+3 accepted bytes. `done` and `cpu_RESET` = 0 are registered and appear the cycle after the checksum byte is accepted. The final `im_W` coincides with the CSUM-state cycle.
- `in_valid` gaps stall the FSM with no state or counter change.
- `RESET_N` low at any point (including mid-word): all outputs take their reset values immediately (asynchronous). A partially assembled word is discarded.

## Structure
- Package `im_loader_pkg`: state enum; `HDR_BYTES` = 2; `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer`: shift-in of 4 bytes into a 32-bit little-endian word, with byte counter and `word_valid` pulse. The FSM, length check, checksum and memory-port registers live in `im_loader`.

## Test plan
- Nominal load: start; bytes 02 00, 13 00 00 00, 37 01 00 E0, checksum 13^37^01^E0 = C5.
  - `im_W` at addr 0 with 0x00000013, then addr 1 with 0xE0000137.
  - `done` = 1 and `cpu_RESET` = 0 one cycle after the C5 byte.
- Bad checksum: same image with checksum 00 -> `err` = 1, `cpu_RESET` stays 1, both writes still occur. A following `start` clears `err`.
- Length bounds:
  - len 0x0000 -> ERROR after the 2nd byte, no `im_W`.
  - len = DEPTH + 1 -> ERROR.
  - len = DEPTH -> last write at address DEPTH-1, then DONE.
- Stalls: random `in_valid` gaps within a 3-word load -> identical writes and checksum result. `start` pulsed during DATA is ignored.
- Reset mid-word: assert `RESET_N` = 0 after 2 bytes of word 1 -> all outputs at reset values immediately. A fresh load afterwards writes addr 0 correctly.
- Reload: after DONE, `start` -> `cpu_RESET` = 1 again on the next cycle; a second image overwrites addresses from 0.
